// File: rtl/pipeline_ctrl_gen.sv
// rtl/pipeline_ctrl_gen.sv - per-stage stall/bubble generation and exception/ERET flush sequencing
// The redirect FSM waits out outstanding bus traffic, then holds flush for FLUSH_CYCLES cycles.
module pipeline_ctrl_gen #(
  parameter int                        STAGES         = 6,
  parameter int                        ADDR_WIDTH     = 32,
  parameter int                        EXC_TYPE_WIDTH = 32,
  parameter logic [EXC_TYPE_WIDTH-1:0] EXC_TYPE_NULL  = '0,
  parameter logic [EXC_TYPE_WIDTH-1:0] EXC_TYPE_ERET  = 32'h0000000e,
  parameter logic [ADDR_WIDTH-1:0]     INIT_PC        = 32'hbfc00000,
  parameter logic [ADDR_WIDTH-1:0]     EXC_PC         = 32'hbfc00380,
  parameter int                        FLUSH_CYCLES   = 1,
  parameter int                        CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [STAGES-1:0]         stall_req,
  input  logic                      bus_busy,
  input  logic [EXC_TYPE_WIDTH-1:0] exception_type,
  input  logic [ADDR_WIDTH-1:0]     cp0_epc,
  input  logic                      stat_clear,
  output logic [STAGES-1:0]         stall,
  output logic [STAGES-1:0]         bubble,
  output logic                      flush,
  output logic [ADDR_WIDTH-1:0]     exc_pc,
  output logic                      busy,
  output logic [CNT_WIDTH-1:0]      stall_count
);

  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FCW-1:0] FLUSH_LOAD = FCW'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_BUS = 2'd1,
    S_FLUSH    = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [ADDR_WIDTH-1:0]   r_target;
  logic [ADDR_WIDTH-1:0]   w_target_next;
  logic [ADDR_WIDTH-1:0]   r_exc_pc;
  logic [FCW-1:0]          r_flush_cnt;
  logic [FCW-1:0]          w_flush_cnt_next;
  logic [CNT_WIDTH-1:0]    r_stall_count;
  logic [STAGES-1:0]       w_stall;
  logic [STAGES-1:0]       w_bubble;
  logic                    w_acc;

  always_comb begin
    w_state_next     = r_state;
    w_target_next    = r_target;
    w_flush_cnt_next = r_flush_cnt;
    w_stall          = '0;
    w_bubble         = '0;
    w_acc            = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A request from stage k holds every younger stage 0..k behind it.
        for (int j = STAGES - 1; j >= 0; j--) begin
          w_acc      = w_acc | stall_req[j];
          w_stall[j] = w_acc;
        end
        for (int j = 1; j < STAGES; j++) begin
          w_bubble[j] = w_stall[j-1] & ~w_stall[j];
        end
        if (exception_type != EXC_TYPE_NULL) begin
          w_target_next = (exception_type == EXC_TYPE_ERET) ? cp0_epc : EXC_PC;
          if (bus_busy) begin
            w_state_next = S_WAIT_BUS;
          end else begin
            w_state_next     = S_FLUSH;
            w_flush_cnt_next = FLUSH_LOAD;
          end
        end
      end
      S_WAIT_BUS: begin
        w_stall = '1;
        if (!bus_busy) begin
          w_state_next     = S_FLUSH;
          w_flush_cnt_next = FLUSH_LOAD;
        end
      end
      S_FLUSH: begin
        if (r_flush_cnt == '0) begin
          w_state_next = S_IDLE;
        end else begin
          w_flush_cnt_next = r_flush_cnt - FCW'(1);
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_target      <= '0;
      r_flush_cnt   <= '0;
      r_exc_pc      <= INIT_PC;
      r_stall_count <= '0;
    end else begin
      r_state     <= w_state_next;
      r_target    <= w_target_next;
      r_flush_cnt <= w_flush_cnt_next;
      r_exc_pc    <= (w_state_next == S_FLUSH) ? w_target_next : INIT_PC;
      if (stat_clear) begin
        r_stall_count <= '0;
      end else if (w_stall[0] && !(&r_stall_count)) begin
        r_stall_count <= r_stall_count + CNT_WIDTH'(1);
      end
    end
  end

  assign stall       = w_stall;
  assign bubble      = w_bubble;
  assign flush       = (r_state == S_FLUSH);
  assign exc_pc      = r_exc_pc;
  assign busy        = (r_state != S_IDLE);
  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_pipeline_ctrl_gen.sv
// tb/tb_pipeline_ctrl_gen.sv - self-checking bench for pipeline_ctrl_gen
// dut_a: FLUSH_CYCLES=1, CNT_WIDTH=4; dut_b: FLUSH_CYCLES=3, CNT_WIDTH=32; both share stimulus.
module tb_pipeline_ctrl_gen;

  localparam logic [31:0] IP   = 32'hbfc00000;
  localparam logic [31:0] EP   = 32'hbfc00380;
  localparam logic [31:0] ERET = 32'h0000000e;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall_req;
  logic        bus_busy;
  logic [31:0] exception_type;
  logic [31:0] cp0_epc;
  logic        stat_clear;

  logic [5:0]  a_stall, a_bubble, b_stall, b_bubble;
  logic        a_flush, a_busy, b_flush, b_busy;
  logic [31:0] a_exc_pc, b_exc_pc;
  logic [3:0]  a_count;
  logic [31:0] b_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipeline_ctrl_gen #(.FLUSH_CYCLES(1), .CNT_WIDTH(4)) dut_a (
    .clk(clk), .rst(rst), .stall_req(stall_req), .bus_busy(bus_busy),
    .exception_type(exception_type), .cp0_epc(cp0_epc), .stat_clear(stat_clear),
    .stall(a_stall), .bubble(a_bubble), .flush(a_flush), .exc_pc(a_exc_pc),
    .busy(a_busy), .stall_count(a_count)
  );

  pipeline_ctrl_gen #(.FLUSH_CYCLES(3), .CNT_WIDTH(32)) dut_b (
    .clk(clk), .rst(rst), .stall_req(stall_req), .bus_busy(bus_busy),
    .exception_type(exception_type), .cp0_epc(cp0_epc), .stat_clear(stat_clear),
    .stall(b_stall), .bubble(b_bubble), .flush(b_flush), .exc_pc(b_exc_pc),
    .busy(b_busy), .stall_count(b_count)
  );

  typedef struct {
    string       name;
    int          sel;
    logic [5:0]  e_stall;
    logic [5:0]  e_bub;
    logic        e_flush;
    logic [31:0] e_pc;
    logic        e_busy;
  } exp_t;

  typedef struct {
    logic [5:0] sreq;
    logic [5:0] e_stall;
    logic [5:0] e_bub;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input string name, input int sel,
                       input logic [5:0] sreq, input logic bb, input logic [31:0] exc,
                       input logic [31:0] epc, input logic clr,
                       input logic [5:0] es, input logic [5:0] eb, input logic ef,
                       input logic [31:0] ep, input logic ebz);
    exp_t e;
    stall_req      = sreq;
    bus_busy       = bb;
    exception_type = exc;
    cp0_epc        = epc;
    stat_clear     = clr;
    e.name = name; e.sel = sel; e.e_stall = es; e.e_bub = eb;
    e.e_flush = ef; e.e_pc = ep; e.e_busy = ebz;
    exp_q.push_back(e);
    @(negedge clk);
    e = exp_q.pop_front();
    if (e.sel == 0) begin
      chk({e.name, ".stall"},  a_stall,  e.e_stall);
      chk({e.name, ".bubble"}, a_bubble, e.e_bub);
      chk({e.name, ".flush"},  a_flush,  e.e_flush);
      chk({e.name, ".exc_pc"}, a_exc_pc, e.e_pc);
      chk({e.name, ".busy"},   a_busy,   e.e_busy);
    end else begin
      chk({e.name, ".stall"},  b_stall,  e.e_stall);
      chk({e.name, ".bubble"}, b_bubble, e.e_bub);
      chk({e.name, ".flush"},  b_flush,  e.e_flush);
      chk({e.name, ".exc_pc"}, b_exc_pc, e.e_pc);
      chk({e.name, ".busy"},   b_busy,   e.e_busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_chk(input string name, input int sel);
    apply(name, sel, 6'h00, 1'b0, 32'h0, 32'h0, 1'b0, 6'h00, 6'h00, 1'b0, IP, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{6'b000100, 6'b000111, 6'b001000};
    tbl[1] = '{6'b001100, 6'b001111, 6'b010000};
    tbl[2] = '{6'b000000, 6'b000000, 6'b000000};
    tbl[3] = '{6'b100001, 6'b111111, 6'b000000};
    tbl[4] = '{6'b000001, 6'b000001, 6'b000010};
    tbl[5] = '{6'b010010, 6'b011111, 6'b100000};
    tbl[6] = '{6'b100000, 6'b111111, 6'b000000};
    tbl[7] = '{6'b000000, 6'b000000, 6'b000000};

    rst = 1'b0; stall_req = '0; bus_busy = 1'b0;
    exception_type = '0; cp0_epc = '0; stat_clear = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.flush", a_flush, 1'b0);
    chk("reset.exc_pc", a_exc_pc, IP);
    chk("reset.busy", a_busy, 1'b0);
    chk("reset.count", a_count, 4'd0);
    chk("reset.stall", a_stall, 6'h00);
    chk("reset.b_exc_pc", b_exc_pc, IP);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Combinational stall/bubble in IDLE
    for (int i = 0; i < 8; i++) begin
      apply($sformatf("vec%0d", i), 0, tbl[i].sreq, 1'b0, 32'h0, 32'h0, 1'b0,
            tbl[i].e_stall, tbl[i].e_bub, 1'b0, IP, 1'b0);
      if (i == 0) chk("count_after_first", a_count, 4'd1);
    end
    chk("count_after_table_a", a_count, 4'd6);
    chk("count_after_table_b", b_count, 32'd6);

    apply("clear", 0, 6'b000001, 1'b0, 32'h0, 32'h0, 1'b1, 6'b000001, 6'b000010, 1'b0, IP, 1'b0);
    chk("clear_prio_a", a_count, 4'd0);
    chk("clear_prio_b", b_count, 32'd0);

    // Exception, bus idle, single-cycle flush
    apply("exc_n",  0, 6'h00, 1'b0, 32'h5, 32'h0, 1'b0, 6'h00, 6'h00, 1'b0, IP, 1'b0);
    apply("exc_n1", 0, 6'h00, 1'b0, 32'h0, 32'h0, 1'b0, 6'h00, 6'h00, 1'b1, EP, 1'b1);
    idle_chk("exc_n2", 0);
    apply("exc_b3", 1, 6'h00, 1'b0, 32'h0, 32'h0, 1'b0, 6'h00, 6'h00, 1'b1, EP, 1'b1);
    idle_chk("exc_b4", 1);

    // ERET with bus busy for four cycles; second exception during the wait is ignored
    apply("eret_n",  0, 6'h00,     1'b1, ERET,  32'h80001234, 1'b0, 6'h00, 6'h00, 1'b0, IP, 1'b0);
    apply("eret_w1", 0, 6'h00,     1'b1, 32'h5, 32'hdeadbeef, 1'b0, 6'h3f, 6'h00, 1'b0, IP, 1'b1);
    apply("eret_w2", 0, 6'b000010, 1'b1, 32'h0, 32'h0,        1'b0, 6'h3f, 6'h00, 1'b0, IP, 1'b1);
    apply("eret_w3", 0, 6'h00,     1'b1, 32'h0, 32'h0,        1'b0, 6'h3f, 6'h00, 1'b0, IP, 1'b1);
    apply("eret_w4", 0, 6'h00,     1'b0, 32'h0, 32'h0,        1'b0, 6'h3f, 6'h00, 1'b0, IP, 1'b1);
    apply("eret_f",  0, 6'h00,     1'b0, 32'h0, 32'h0,        1'b0, 6'h00, 6'h00, 1'b1, 32'h80001234, 1'b1);
    idle_chk("eret_done", 0);
    apply("eret_b_f3", 1, 6'h00, 1'b0, 32'h0, 32'h0, 1'b0, 6'h00, 6'h00, 1'b1, 32'h80001234, 1'b1);
    idle_chk("eret_b_done", 1);
    chk("count_eret_a", a_count, 4'd4);
    chk("count_eret_b", b_count, 32'd4);

    // Three-cycle flush with full stall request; exceptions during FLUSH ignored
    apply("f3_n", 1, 6'h3f, 1'b0, 32'h5, 32'h0,        1'b0, 6'h3f, 6'h00, 1'b0, IP, 1'b0);
    apply("f3_1", 1, 6'h3f, 1'b0, ERET,  32'h12345678, 1'b0, 6'h00, 6'h00, 1'b1, EP, 1'b1);
    apply("f3_2", 1, 6'h3f, 1'b0, 32'h5, 32'h0,        1'b0, 6'h00, 6'h00, 1'b1, EP, 1'b1);
    chk("b2b_a_flush", a_flush, 1'b1);
    chk("b2b_a_exc_pc", a_exc_pc, EP);
    apply("f3_3", 1, 6'h3f, 1'b0, 32'h0, 32'h0,        1'b0, 6'h00, 6'h00, 1'b1, EP, 1'b1);
    idle_chk("f3_done", 1);
    chk("count_f3_a", a_count, 4'd6);
    chk("count_f3_b", b_count, 32'd5);

    // Asynchronous reset in the middle of WAIT_BUS
    apply("rw_n", 0, 6'h00, 1'b1, 32'h5, 32'h0, 1'b0, 6'h00, 6'h00, 1'b0, IP, 1'b0);
    apply("rw_w", 0, 6'h00, 1'b1, 32'h0, 32'h0, 1'b0, 6'h3f, 6'h00, 1'b0, IP, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("rw_rst.stall", a_stall, 6'h00);
    chk("rw_rst.busy", a_busy, 1'b0);
    chk("rw_rst.flush", a_flush, 1'b0);
    chk("rw_rst.exc_pc", a_exc_pc, IP);
    chk("rw_rst.count", a_count, 4'd0);
    chk("rw_rst.b_busy", b_busy, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    bus_busy = 1'b0;
    @(posedge clk);
    #1;
    idle_chk("rw_after_a", 0);
    idle_chk("rw_after_b", 1);

    // Saturation of the 4-bit counter, then clear
    for (int i = 0; i < 17; i++) begin
      apply("sat", 0, 6'b000001, 1'b0, 32'h0, 32'h0, 1'b0, 6'b000001, 6'b000010, 1'b0, IP, 1'b0);
    end
    chk("sat_a", a_count, 4'd15);
    chk("sat_b", b_count, 32'd17);
    apply("sat_clr", 0, 6'b000001, 1'b0, 32'h0, 32'h0, 1'b1, 6'b000001, 6'b000010, 1'b0, IP, 1'b0);
    chk("sat_clr_a", a_count, 4'd0);
    chk("sat_clr_b", b_count, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
